// File: rtl/equ_lock_detect.sv
// equ_lock_detect
//   Qualifies a stream of per-sample equality results (z from the 2-bit
//   equality checker) into a stable lock indication. A hysteresis FSM needs
//   LOCK_CNT consecutive valid matches to acquire lock and LOSE_CNT
//   consecutive valid mismatches to drop it. A saturating counter also
//   tracks every valid mismatch, for status readback.
//
//   Optional feature: define EQU_LOCK_STATS_EN to add lock_cnt, a saturating
//   count of lock acquisitions.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   z           in   equality result (1 = match)
//   z_valid     in   z is sampled only when high
//   clr         in   synchronous clear of FSM and counters
//   locked      out  high in LOCKED or HOLD
//   lock_pulse  out  one-cycle pulse on lock acquisition
//   lose_pulse  out  one-cycle pulse on lock loss
//   state       out  SEARCH=00, CONFIRM=01, LOCKED=10, HOLD=11
//   err_cnt     out  saturating count of valid mismatches
//   lock_cnt    out  (EQU_LOCK_STATS_EN only) saturating lock count
module equ_lock_detect #(
    parameter int LOCK_CNT = 4,
    parameter int LOSE_CNT = 2,
    parameter int CW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          z,
    input  logic          z_valid,
    input  logic          clr,
    output logic          locked,
    output logic          lock_pulse,
    output logic          lose_pulse,
    output logic [1:0]    state,
    output logic [CW-1:0] err_cnt
`ifdef EQU_LOCK_STATS_EN
    ,
    output logic [CW-1:0] lock_cnt
`endif
);

    typedef enum logic [1:0] {
        SEARCH  = 2'b00,
        CONFIRM = 2'b01,
        LOCKED  = 2'b10,
        HOLD    = 2'b11
    } state_t;

    // Targets compared against a 9-bit incremented counter so the +1 never
    // truncates, whatever value the 8-bit counter holds.
    localparam logic [8:0] LOCK_TGT = 9'(LOCK_CNT);
    localparam logic [8:0] LOSE_TGT = 9'(LOSE_CNT);

    state_t        state_q, state_d;
    logic [7:0]    run_q, run_d;
    logic [7:0]    miss_q, miss_d;
    logic [CW-1:0] err_q, err_d;
    logic          lock_pulse_q, lock_pulse_d;
    logic          lose_pulse_q, lose_pulse_d;
    logic [8:0]    run_nxt, miss_nxt;

    assign run_nxt  = {1'b0, run_q} + 9'd1;
    assign miss_nxt = {1'b0, miss_q} + 9'd1;

    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        miss_d       = miss_q;
        err_d        = err_q;
        lock_pulse_d = 1'b0;
        lose_pulse_d = 1'b0;
        if (clr) begin
            state_d = SEARCH;
            run_d   = '0;
            miss_d  = '0;
            err_d   = '0;
        end else if (z_valid) begin
            if (!z && (err_q != '1))
                err_d = err_q + CW'(1);
            case (state_q)
                SEARCH: begin
                    if (z) begin
                        run_d = 8'd1;
                        if (LOCK_CNT == 1) begin
                            state_d      = LOCKED;
                            lock_pulse_d = 1'b1;
                        end else begin
                            state_d = CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (z) begin
                        if (run_nxt == LOCK_TGT) begin
                            state_d      = LOCKED;
                            lock_pulse_d = 1'b1;
                            run_d        = '0;
                        end else begin
                            run_d = run_nxt[7:0];
                        end
                    end else begin
                        run_d   = '0;
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    if (!z) begin
                        miss_d = 8'd1;
                        if (LOSE_CNT == 1) begin
                            state_d      = SEARCH;
                            lose_pulse_d = 1'b1;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (z) begin
                        miss_d  = '0;
                        state_d = LOCKED;
                    end else if (miss_nxt == LOSE_TGT) begin
                        state_d      = SEARCH;
                        lose_pulse_d = 1'b1;
                        miss_d       = '0;
                    end else begin
                        miss_d = miss_nxt[7:0];
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SEARCH;
            run_q        <= '0;
            miss_q       <= '0;
            err_q        <= '0;
            lock_pulse_q <= 1'b0;
            lose_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            miss_q       <= miss_d;
            err_q        <= err_d;
            lock_pulse_q <= lock_pulse_d;
            lose_pulse_q <= lose_pulse_d;
        end
    end

    // LOCKED and HOLD share the MSB, so locked comes straight off a flop.
    assign locked     = state_q[1];
    assign lock_pulse = lock_pulse_q;
    assign lose_pulse = lose_pulse_q;
    assign state      = state_q;
    assign err_cnt    = err_q;

`ifdef EQU_LOCK_STATS_EN
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (clr)
            lock_cnt_d = '0;
        else if (lock_pulse_d && (lock_cnt_q != '1))
            lock_cnt_d = lock_cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lock_cnt_q <= '0;
        else     lock_cnt_q <= lock_cnt_d;
    end

    assign lock_cnt = lock_cnt_q;
`endif

endmodule

// File: doc/equ_lock_detect.md
Name: equ_lock_detect

Overview:
- Downstream consumer of the 2-bit equality checker's `z` output.
- Qualifies a stream of per-sample equality results into a stable "locked" indication using a hysteresis state machine:
  - LOCK_CNT consecutive matches are required to acquire lock.
  - LOSE_CNT consecutive mismatches are required to drop lock.
- Also keeps a saturating count of all mismatches, for status/debug readback.

Parameters:
- LOCK_CNT, 4: consecutive valid matches needed to enter lock. Legal range 1..255.
- LOSE_CNT, 2: consecutive valid mismatches needed to leave lock. Legal range 1..255.
- CW, 8: width of the mismatch counter err_cnt.

Ports:
- clk      input   1   system clock; all state updates on rising edge.
- rst      input   1   asynchronous, active-high reset.
- z        input   1   equality result from the checker (1 = x equals y).
- z_valid  input   1   z is sampled only on edges where z_valid = 1.
- clr      input   1   synchronous clear of FSM and counters.
- locked   output  1   registered; high in LOCKED or HOLD.
- lock_pulse  output  1   registered; one-cycle pulse on entry to LOCKED from CONFIRM/SEARCH.
- lose_pulse  output  1   registered; one-cycle pulse on return to SEARCH from LOCKED/HOLD.
- state    output  2   current FSM state: SEARCH=00, CONFIRM=01, LOCKED=10, HOLD=11.
- err_cnt  output  CW  saturating count of valid mismatches.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values (while rst=1): state=SEARCH, locked=0, lock_pulse=0, lose_pulse=0, err_cnt=0. Internal run and miss counters are 0.
- Registers and latency:
  - All outputs are registered.
  - A sample taken at edge k is reflected in the outputs immediately after edge k (latency 1).
- z_valid=0: all state and counters hold. lock_pulse and lose_pulse return to 0.
- Pulses: lock_pulse and lose_pulse are high for exactly one cycle per qualifying transition, and 0 otherwise.
- clr=1: highest priority after rst.
  - Next state is SEARCH; run, miss and err_cnt go to 0; pulses go to 0.
  - z_valid on the same edge is ignored.
- FSM transitions (apply only when z_valid=1 and clr=0):
  - SEARCH:
    - z=1: run=1. If LOCK_CNT==1, go to LOCKED and set lock_pulse. Otherwise go to CONFIRM.
    - z=0: stay in SEARCH.
  - CONFIRM:
    - z=1: run=run+1. When run+1 == LOCK_CNT, go to LOCKED, set lock_pulse, and set run=0.
    - z=0: run=0, go to SEARCH.
  - LOCKED:
    - z=1: stay in LOCKED.
    - z=0: miss=1. If LOSE_CNT==1, go to SEARCH and set lose_pulse. Otherwise go to HOLD.
  - HOLD:
    - z=1: miss=0, return to LOCKED. No pulse.
    - z=0: miss=miss+1. When miss+1 == LOSE_CNT, go to SEARCH, set lose_pulse, and set miss=0.
- err_cnt:
  - Increments by 1 on every edge with z_valid=1 and z=0, in any state.
  - Saturates at 2^CW-1; it never wraps.
  - Cleared only by rst or clr.
- Counter widths: run and miss are 8 bits and cannot overflow within the legal parameter range.
- locked = (state==LOCKED) or (state==HOLD), derived from the state register (glitch-free).
- Reset mid-operation: an async assertion forces the reset values immediately, regardless of the clock. Deassertion resumes from SEARCH.

Optional Feature:
- Macro: EQU_LOCK_STATS_EN.
- Defined:
  - Adds output port lock_cnt [CW-1:0].
  - lock_cnt increments on each edge that sets lock_pulse and saturates at 2^CW-1.
  - Cleared by rst or clr; reset value 0.
- Not defined:
  - Port lock_cnt and its register are absent.
  - All other behaviour is identical.

Test Plan:
- Reset check: rst=1 for 3 cycles, then 0, with z_valid=0 -> state=00, locked=0, err_cnt=0, both pulses 0.
- Lock acquire (LOCK_CNT=4): z_valid=1, z=1 for 4 cycles -> state 01,01,01,10; lock_pulse=1 only after the 4th edge; locked=1 from then.
- Broken confirm: z=1,1,1,0,1,1,1,1 -> SEARCH after the 4th sample; lock only after the 8th sample; err_cnt=1.
- Hysteresis (LOSE_CNT=2): from LOCKED, z=0,1,0,0:
  - HOLD (locked stays 1), then LOCKED, HOLD, SEARCH.
  - lose_pulse=1 only after the last edge; err_cnt increments by 3.
- Gaps and clear:
  - z_valid toggled 1/0 with z=1 -> lock after 4 valid samples, not 4 cycles.
  - Then clr=1 together with z_valid=1, z=0 -> state=00, err_cnt=0, no lose_pulse.
- Saturation and async reset:
  - CW=3: 9 mismatches -> err_cnt=7, held at 7.
  - rst asserted mid-CONFIRM, between clock edges -> outputs go to reset values immediately.
  - With EQU_LOCK_STATS_EN: 2 lock acquisitions -> lock_cnt=2.
